// File: rtl/led_status_counter.sv
// ============================================================================
// Module   : led_status_counter
// Purpose  : Board-status LED driver. It has a prescaled up-counter with load
//            and a wrap flag, and it offers four display modes: count, per-LED
//            activity stretch, bouncing scanner, and freeze.
// Option   : define SYNC_EVENT_EN to pass EVENT through a 2-flop synchronizer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module led_status_counter #(
   parameter int CNT_W     = 28,
   parameter int LED_W     = 8,
   parameter int PRESCALE  = 1,
   parameter int STRETCH_W = 20
) (
   input  logic               CK12,
   input  logic               CLEAR,
   input  logic               EN,
   input  logic [1:0]         MODE,
   input  logic               LOAD,
   input  logic [CNT_W-1:0]   LOAD_VAL,
   input  logic [LED_W-1:0]   EVENT,
   output logic [LED_W-1:0]   LED,
   output logic               WRAP
);

   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;
   localparam int LOW_W = CNT_W - LED_W;

   localparam logic [PS_W-1:0]  C_PS_LAST  = PS_W'(PRESCALE - 1);
   localparam logic [POS_W-1:0] C_POS_LAST = POS_W'(LED_W - 1);

   localparam logic [1:0] C_MODE_COUNT    = 2'd0;
   localparam logic [1:0] C_MODE_ACTIVITY = 2'd1;
   localparam logic [1:0] C_MODE_SCANNER  = 2'd2;

   logic [LED_W-1:0] w_event;
   logic [PS_W-1:0]  r_ps;
   logic [CNT_W-1:0] r_cnt;
   logic             r_wrap;
   logic [LED_W-1:0] r_led;
   logic [LED_W-1:0] w_active;
   logic [POS_W-1:0] w_pos;
   logic [LED_W-1:0] w_onehot;
   logic             w_ps_last;
   logic             w_tick;
   logic             w_scan_step;

`ifdef SYNC_EVENT_EN
   logic [LED_W-1:0] r_ev_meta;
   logic [LED_W-1:0] r_ev_sync;

   always_ff @(posedge CK12) begin
      if (CLEAR) begin
         r_ev_meta <= '0;
         r_ev_sync <= '0;
      end else begin
         r_ev_meta <= EVENT;
         r_ev_sync <= r_ev_meta;
      end
   end

   assign w_event = r_ev_sync;
`else
   assign w_event = EVENT;
`endif

   // LOAD suppresses the tick, so a load never counts, wraps or steps the scanner.
   assign w_ps_last   = (r_ps == C_PS_LAST);
   assign w_tick      = EN && !LOAD && w_ps_last;
   assign w_scan_step = w_tick && (&r_cnt[LOW_W-1:0]);

   always_ff @(posedge CK12) begin
      if (CLEAR) begin
         r_ps   <= '0;
         r_cnt  <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_tick && (&r_cnt);
         if (LOAD) begin
            r_cnt <= LOAD_VAL;
            r_ps  <= '0;
         end else if (EN) begin
            if (w_ps_last) begin
               r_ps  <= '0;
               r_cnt <= r_cnt + CNT_W'(1);
            end else begin
               r_ps  <= r_ps + PS_W'(1);
            end
         end
      end
   end

   generate
      if (LED_W > 1) begin : g_scan_multi
         typedef enum logic [0:0] {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
         dir_t             r_dir;
         logic [POS_W-1:0] r_pos;

         always_ff @(posedge CK12) begin
            if (CLEAR) begin
               r_pos <= '0;
               r_dir <= DIR_UP;
            end else if (w_scan_step) begin
               case (r_dir)
                  DIR_UP: begin
                     if (r_pos == C_POS_LAST) begin
                        r_dir <= DIR_DOWN;
                        r_pos <= r_pos - POS_W'(1);
                     end else begin
                        r_pos <= r_pos + POS_W'(1);
                     end
                  end
                  default: begin
                     if (r_pos == '0) begin
                        r_dir <= DIR_UP;
                        r_pos <= r_pos + POS_W'(1);
                     end else begin
                        r_pos <= r_pos - POS_W'(1);
                     end
                  end
               endcase
            end
         end

         assign w_pos = r_pos;
      end else begin : g_scan_single
         assign w_pos = '0;
      end
   endgenerate

   assign w_onehot = LED_W'(1) << w_pos;

   generate
      for (genvar i = 0; i < LED_W; i++) begin : g_stretch
         logic [STRETCH_W-1:0] r_str;

         always_ff @(posedge CK12) begin
            if (CLEAR) begin
               r_str <= '0;
            end else if (w_event[i]) begin
               r_str <= '1;
            end else if (r_str != '0) begin
               r_str <= r_str - STRETCH_W'(1);
            end
         end

         assign w_active[i] = |r_str;
      end
   endgenerate

   // Freeze (and any unlisted code) simply keeps the previous LED value.
   always_ff @(posedge CK12) begin
      if (CLEAR) begin
         r_led <= '0;
      end else begin
         case (MODE)
            C_MODE_COUNT:    r_led <= r_cnt[CNT_W-1 -: LED_W];
            C_MODE_ACTIVITY: r_led <= w_active;
            C_MODE_SCANNER:  r_led <= w_onehot;
            default:         r_led <= r_led;
         endcase
      end
   end

   assign LED  = r_led;
   assign WRAP = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_led_status_counter.sv
// ============================================================================
// Module   : tb_led_status_counter
// Purpose  : Self-checking bench for led_status_counter against a cycle-level
//            arithmetic reference model (SYNC_EVENT_EN honoured if defined).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_status_counter;

   localparam int CNT_W     = 8;
   localparam int LED_W     = 4;
   localparam int PRESCALE  = 2;
   localparam int STRETCH_W = 3;
   localparam int STR_MAX   = (1 << STRETCH_W) - 1;
   localparam int CNT_MOD   = 1 << CNT_W;
   localparam int LOW_MOD   = 1 << (CNT_W - LED_W);

   logic             clk      = 1'b0;
   logic             clear    = 1'b1;
   logic             en       = 1'b0;
   logic [1:0]       mode     = 2'd0;
   logic             load     = 1'b0;
   logic [CNT_W-1:0] load_val = '0;
   logic [LED_W-1:0] ev       = '0;
   logic [LED_W-1:0] led;
   logic             wrap;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   led_status_counter #(
      .CNT_W(CNT_W), .LED_W(LED_W), .PRESCALE(PRESCALE), .STRETCH_W(STRETCH_W)
   ) dut (
      .CK12(clk), .CLEAR(clear), .EN(en), .MODE(mode), .LOAD(load),
      .LOAD_VAL(load_val), .EVENT(ev), .LED(led), .WRAP(wrap)
   );

   // Reference model: counter as an integer, scanner as a count of steps
   // folded onto a triangle wave, stretchers as integer countdowns.
   int               m_cnt   = 0;
   int               m_ps    = 0;
   int               m_steps = 0;
   int               m_str[LED_W];
   logic [LED_W-1:0] m_led   = '0;
   logic             m_wrap  = 1'b0;
   logic [LED_W-1:0] m_ev_eff;
   logic [LED_W-1:0] m_act;
   logic             m_tick;
`ifdef SYNC_EVENT_EN
   logic [LED_W-1:0] m_ev_d1 = '0;
   logic [LED_W-1:0] m_ev_d2 = '0;
`endif

   function automatic int scan_pos(input int steps);
      int period;
      int k;
      period = 2 * (LED_W - 1);
      k      = steps % period;
      return (k < LED_W) ? k : period - k;
   endfunction

   initial for (int i = 0; i < LED_W; i++) m_str[i] = 0;

   always @(posedge clk) begin
`ifdef SYNC_EVENT_EN
      m_ev_eff = m_ev_d2;
      if (clear) begin
         m_ev_d1 = '0;
         m_ev_d2 = '0;
      end else begin
         m_ev_d2 = m_ev_d1;
         m_ev_d1 = ev;
      end
`else
      m_ev_eff = ev;
`endif
      if (clear) begin
         m_cnt   = 0;
         m_ps    = 0;
         m_steps = 0;
         m_led   = '0;
         m_wrap  = 1'b0;
         for (int i = 0; i < LED_W; i++) m_str[i] = 0;
      end else begin
         for (int i = 0; i < LED_W; i++) m_act[i] = (m_str[i] != 0);
         case (mode)
            2'd0:    m_led = LED_W'(m_cnt / LOW_MOD);
            2'd1:    m_led = m_act;
            2'd2:    m_led = LED_W'(1 << scan_pos(m_steps));
            default: m_led = m_led;
         endcase
         m_tick = en && !load && (m_ps == PRESCALE - 1);
         m_wrap = m_tick && (m_cnt == CNT_MOD - 1);
         if (m_tick && (m_cnt % LOW_MOD == LOW_MOD - 1)) m_steps++;
         if (load) begin
            m_cnt = int'(load_val);
            m_ps  = 0;
         end else if (en) begin
            if (m_ps == PRESCALE - 1) begin
               m_ps  = 0;
               m_cnt = (m_cnt + 1) % CNT_MOD;
            end else begin
               m_ps++;
            end
         end
         for (int i = 0; i < LED_W; i++) begin
            if (m_ev_eff[i])        m_str[i] = STR_MAX;
            else if (m_str[i] > 0)  m_str[i] = m_str[i] - 1;
         end
      end
   end

   task automatic test_reset;
      for (int c = 0; c < 2; c++) begin
         clear = 1'b1; en = 1'($urandom); load = 1'($urandom);
         mode = 2'($urandom); load_val = 8'($urandom); ev = 4'($urandom);
         @(negedge clk);
      end
      checks++;
      if (led !== 4'h0 || wrap !== 1'b0) begin
         failures++;
         $display("FAIL reset_state led=%h wrap=%b required led=0 wrap=0", led, wrap);
      end
      clear = 1'b0; en = 1'b1; mode = 2'd0; load = 1'b0; ev = '0;
      for (int c = 0; c < 33; c++) begin
         @(negedge clk);
         checks++;
         if (led !== m_led || wrap !== m_wrap) begin
            failures++;
            $display("FAIL count_run cyc=%0d led=%h wrap=%b required led=%h wrap=%b",
                     c, led, wrap, m_led, m_wrap);
         end
      end
      checks++;
      if (led !== 4'h1) begin
         failures++;
         $display("FAIL count_16_ticks led=%h required 1", led);
      end
   endtask

   task automatic test_wrap;
      int wraps;
      @(negedge clk);
      en = 1'b0; mode = 2'd0; load = 1'b1; load_val = 8'hFE;
      @(negedge clk);
      load = 1'b0; en = 1'b1; wraps = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (wrap === 1'b1) wraps++;
         checks++;
         if (led !== m_led || wrap !== m_wrap) begin
            failures++;
            $display("FAIL wrap_run cyc=%0d led=%h wrap=%b required led=%h wrap=%b",
                     c, led, wrap, m_led, m_wrap);
         end
      end
      checks++;
      if (wraps != 1) begin
         failures++;
         $display("FAIL wrap_pulse_count got=%0d required 1", wraps);
      end
      en = 1'b0; load = 1'b1; load_val = 8'hA5;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      checks++;
      if (led !== 4'hA || led !== m_led) begin
         failures++;
         $display("FAIL load_no_en led=%h required A (model %h)", led, m_led);
      end
   endtask

   task automatic test_activity;
      int high;
      mode = 2'd1; en = 1'b0; ev = '0;
      repeat (12) @(negedge clk);
      ev = 4'b0100;
      high = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         ev = '0;
         if (led[2] === 1'b1) high++;
         checks++;
         if (led !== m_led || led[3] !== 1'b0 || led[1:0] !== 2'b00) begin
            failures++;
            $display("FAIL activity_single cyc=%0d led=%h required %h", c, led, m_led);
         end
      end
      checks++;
      if (high != STR_MAX) begin
         failures++;
         $display("FAIL activity_width got=%0d required %0d", high, STR_MAX);
      end
      ev = 4'b0100;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         ev = (c == 4) ? 4'b0100 : 4'b0000;
         checks++;
         if (led !== m_led) begin
            failures++;
            $display("FAIL activity_retrigger cyc=%0d led=%h required %h", c, led, m_led);
         end
      end
   endtask

   task automatic test_scanner;
      logic [LED_W-1:0] seq[$];
      logic [LED_W-1:0] exp_seq[8];
      logic [LED_W-1:0] prev;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0; mode = 2'd2; en = 1'b1; prev = '0;
      for (int c = 0; c < 8 * 32 + 4; c++) begin
         @(negedge clk);
         if (led !== prev) begin
            seq.push_back(led);
            prev = led;
         end
         checks++;
         if (led !== m_led) begin
            failures++;
            $display("FAIL scanner_run cyc=%0d led=%h required %h", c, led, m_led);
         end
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= seq.size() || seq[i] !== exp_seq[i]) begin
            failures++;
            $display("FAIL scanner_seq idx=%0d got=%h required %h", i,
                     (i < seq.size()) ? seq[i] : 4'hx, exp_seq[i]);
         end
      end
   endtask

   task automatic test_midop_reset;
      @(negedge clk);
      mode = 2'd1; ev = 4'hF;
      @(negedge clk);
      ev = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (led !== 4'hF || led !== m_led) begin
         failures++;
         $display("FAIL midop_active led=%h required F", led);
      end
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      checks++;
      if (led !== 4'h0) begin
         failures++;
         $display("FAIL midop_clear led=%h required 0", led);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (led !== 4'h0 || led !== m_led) begin
            failures++;
            $display("FAIL midop_stay_dark cyc=%0d led=%h required 0", c, led);
         end
      end
   endtask

   task automatic test_freeze;
      logic [LED_W-1:0] held;
      @(negedge clk);
      mode = 2'd0; en = 1'b1; load = 1'b1; load_val = 8'h30;
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      mode = 2'd3;
      @(negedge clk);
      held = led;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         checks++;
         if (led !== held || led !== m_led) begin
            failures++;
            $display("FAIL freeze_hold cyc=%0d led=%h required %h", c, led, held);
         end
      end
      mode = 2'd0;
      @(negedge clk);
      checks++;
      if (led !== m_led || led === held) begin
         failures++;
         $display("FAIL freeze_release led=%h required %h", led, m_led);
      end
      clear = 1'b1; load = 1'b1; load_val = 8'hFF; en = 1'b0;
      @(negedge clk);
      clear = 1'b0; load = 1'b0;
      @(negedge clk);
      checks++;
      if (led !== 4'h0 || led !== m_led) begin
         failures++;
         $display("FAIL clear_beats_load led=%h required 0", led);
      end
   endtask

   task automatic test_random;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         checks++;
         if (led !== m_led || wrap !== m_wrap) begin
            failures++;
            $display("FAIL random cyc=%0d led=%h wrap=%b required led=%h wrap=%b",
                     c, led, wrap, m_led, m_wrap);
         end
         clear    = ($urandom_range(199) == 0);
         load     = ($urandom_range(29) == 0);
         load_val = 8'($urandom);
         en       = ($urandom_range(3) != 0);
         if ($urandom_range(39) == 0) mode = 2'($urandom);
         ev       = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_activity();
      test_scanner();
      test_midop_reset();
      test_freeze();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
